// File: rtl/ff_models_pkg.sv
// Shared definitions for the FF_MODELS flop benchmarks: pipeline mode encodings
// and the occupancy-counter width helper.
package ff_models_pkg;

    localparam logic [1:0] MODE_SHIFT = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    // Bits needed to hold a count of 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffenrs_pipe_if.sv
// Control/data bundle of the dffenrs_pipe register pipeline; the driver side
// uses master, the pipeline uses slave.
interface dffenrs_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    import ff_models_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);

    logic                     S;
    logic                     E;
    logic [1:0]               mode;
    logic [WIDTH-1:0]         D;
    logic                     vin;
    logic [WIDTH-1:0]         Q;
    logic                     vout;
    logic [WIDTH*DEPTH-1:0]   Qall;
    logic [CW-1:0]            cnt;

    modport master (output S, E, mode, D, vin, input Q, vout, Qall, cnt);
    modport slave  (input S, E, mode, D, vin, output Q, vout, Qall, cnt);

endinterface

// File: rtl/dffenrs_stage.sv
// W-bit register cell with async reset, sync set and enable, in that priority;
// the active clock edge is chosen at elaboration by NEG_CLK.
module dffenrs_stage #(
    parameter int unsigned   W       = 9,
    parameter bit            NEG_CLK = 1'b1,
    parameter logic [W-1:0]  RST_VAL = '0,
    parameter logic [W-1:0]  SET_VAL = '1
) (
    input  logic          clk,
    input  logic          R,
    input  logic          S,
    input  logic          E,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    generate
        if (NEG_CLK) begin : g_neg
            always_ff @(negedge clk or posedge R) begin
                if (R)      q <= RST_VAL;
                else if (S) q <= SET_VAL;
                else if (E) q <= d;
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge R) begin
                if (R)      q <= RST_VAL;
                else if (S) q <= SET_VAL;
                else if (E) q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/dffenrs_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, a
// registered occupancy count and shift/rotate/broadcast/hold modes.
module dffenrs_pipe #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 4,
    parameter bit                NEG_CLK = 1'b1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter logic [WIDTH-1:0]  SET_VAL = '1
) (
    input  logic          clk,
    input  logic          R,
    dffenrs_pipe_if.slave bus
);
    import ff_models_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);

    // Each cell holds {valid, data}
    logic [WIDTH:0]            cell_q [DEPTH];
    logic [WIDTH:0]            cell_d [DEPTH];
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             cnt_d;
    logic [WIDTH*DEPTH-1:0]    qall;
    logic                      upd_en;

    // HOLD mode is folded into the enable so all cells keep their value
    assign upd_en = bus.E && (bus.mode != MODE_HOLD);

    // Per-stage next value selected by mode
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) cell_d[i] = cell_q[i];
        case (bus.mode)
            MODE_SHIFT: begin
                cell_d[0] = {bus.vin, bus.D};
                for (int unsigned i = 1; i < DEPTH; i++) cell_d[i] = cell_q[i-1];
            end
            MODE_ROT: begin
                cell_d[0] = cell_q[DEPTH-1];
                for (int unsigned i = 1; i < DEPTH; i++) cell_d[i] = cell_q[i-1];
            end
            MODE_BCAST: begin
                for (int unsigned i = 0; i < DEPTH; i++) cell_d[i] = {bus.vin, bus.D};
            end
            default: ;
        endcase
    end

    // Occupancy tracks the valid bits; modular arithmetic keeps shift exact
    always_comb begin
        cnt_d = cnt_q;
        case (bus.mode)
            MODE_SHIFT: cnt_d = cnt_q + CW'(bus.vin) - CW'(cell_q[DEPTH-1][WIDTH]);
            MODE_BCAST: cnt_d = bus.vin ? CW'(DEPTH) : '0;
            default:    ;
        endcase
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            dffenrs_stage #(
                .W       (WIDTH + 1),
                .NEG_CLK (NEG_CLK),
                .RST_VAL ({1'b0, RST_VAL}),
                .SET_VAL ({1'b1, SET_VAL})
            ) u_stage (
                .clk (clk),
                .R   (R),
                .S   (bus.S),
                .E   (upd_en),
                .d   (cell_d[g]),
                .q   (cell_q[g])
            );
        end
    endgenerate

    dffenrs_stage #(
        .W       (CW),
        .NEG_CLK (NEG_CLK),
        .RST_VAL ('0),
        .SET_VAL (CW'(DEPTH))
    ) u_cnt (
        .clk (clk),
        .R   (R),
        .S   (bus.S),
        .E   (upd_en),
        .d   (cnt_d),
        .q   (cnt_q)
    );

    always_comb begin
        qall = '0;
        for (int unsigned i = 0; i < DEPTH; i++) qall[i*WIDTH +: WIDTH] = cell_q[i][WIDTH-1:0];
    end

    assign bus.Q    = cell_q[DEPTH-1][WIDTH-1:0];
    assign bus.vout = cell_q[DEPTH-1][WIDTH];
    assign bus.Qall = qall;
    assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_dffenrs_pipe.sv
// Directed bench for dffenrs_pipe: falling-edge build exercised against hand values
// plus a per-edge reference model, rising-edge build checked for edge polarity.
module tb_dffenrs_pipe;
    import ff_models_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic r_n;
    logic r_p;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [7:0] m_d [DEPTH];
    logic       m_v [DEPTH];

    always #5 clk = ~clk;

    dffenrs_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_n ();
    dffenrs_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_p ();

    dffenrs_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NEG_CLK(1'b1)) dut_n (
        .clk (clk), .R (r_n), .bus (bus_n));
    dffenrs_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NEG_CLK(1'b0)) dut_p (
        .clk (clk), .R (r_p), .bus (bus_p));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) r[i*8 +: 8] = m_d[i];
        return r;
    endfunction

    function automatic int m_pop();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_d[i] = 8'h00;
            m_v[i] = 1'b0;
        end
    endtask

    // One falling edge on dut_n, with the reference model stepped on the same inputs
    task automatic tick_n();
        logic [7:0] nd [DEPTH];
        logic       nv [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            nd[i] = m_d[i];
            nv[i] = m_v[i];
        end
        if (r_n) begin
            for (int i = 0; i < DEPTH; i++) begin nd[i] = 8'h00; nv[i] = 1'b0; end
        end else if (bus_n.S) begin
            for (int i = 0; i < DEPTH; i++) begin nd[i] = 8'hFF; nv[i] = 1'b1; end
        end else if (bus_n.E) begin
            case (bus_n.mode)
                2'b00: begin
                    nd[0] = bus_n.D; nv[0] = bus_n.vin;
                    for (int i = 1; i < DEPTH; i++) begin nd[i] = m_d[i-1]; nv[i] = m_v[i-1]; end
                end
                2'b01: begin
                    nd[0] = m_d[DEPTH-1]; nv[0] = m_v[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin nd[i] = m_d[i-1]; nv[i] = m_v[i-1]; end
                end
                2'b10: begin
                    for (int i = 0; i < DEPTH; i++) begin nd[i] = bus_n.D; nv[i] = bus_n.vin; end
                end
                default: ;
            endcase
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            m_d[i] = nd[i];
            m_v[i] = nv[i];
        end
        chk("model_qall", bus_n.Qall, m_pack());
        chk("model_cnt",  bus_n.cnt,  m_pop());
        chk("model_vout", bus_n.vout, m_v[DEPTH-1]);
    endtask

    task automatic drive_n(input logic s, input logic e, input logic [1:0] md,
                           input logic [7:0] d, input logic v);
        bus_n.S = s; bus_n.E = e; bus_n.mode = md; bus_n.D = d; bus_n.vin = v;
    endtask

    initial begin
        logic [31:0] exp_p [DEPTH];
        logic [7:0]  din_p [DEPTH];
        exp_p[0] = 32'h00000011; exp_p[1] = 32'h00001122;
        exp_p[2] = 32'h00112233; exp_p[3] = 32'h11223344;
        din_p[0] = 8'h11; din_p[1] = 8'h22; din_p[2] = 8'h33; din_p[3] = 8'h44;

        r_n = 1'b0; r_p = 1'b0;
        drive_n(1'b0, 1'b0, MODE_SHIFT, 8'h00, 1'b0);
        bus_p.S = 1'b0; bus_p.E = 1'b0; bus_p.mode = MODE_SHIFT; bus_p.D = 8'h00; bus_p.vin = 1'b0;
        m_reset();
        #1;
        r_n = 1'b1; r_p = 1'b1;
        #1;
        chk("rst_q",    bus_n.Q,    8'h00);
        chk("rst_vout", bus_n.vout, 1'b0);
        chk("rst_cnt",  bus_n.cnt,  3'd0);
        chk("rst_qall", bus_n.Qall, 32'h0);
        chk("rst_p_qall", bus_p.Qall, 32'h0);
        chk("rst_p_cnt",  bus_p.cnt,  3'd0);
        @(negedge clk);
        #1;
        r_n = 1'b0; r_p = 1'b0;

        // Shift latency: first entry reaches Q on the 4th falling edge
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h11, 1'b1); tick_n();
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h22, 1'b1); tick_n();
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h33, 1'b1); tick_n();
        chk("lat3_q",    bus_n.Q,    8'h00);
        chk("lat3_vout", bus_n.vout, 1'b0);
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h44, 1'b1); tick_n();
        chk("shift_q",    bus_n.Q,    8'h11);
        chk("shift_vout", bus_n.vout, 1'b1);
        chk("shift_cnt",  bus_n.cnt,  3'd4);
        chk("shift_qall", bus_n.Qall, 32'h11223344);

        // Async reset between edges
        #2;
        r_n = 1'b1;
        #1;
        m_reset();
        chk("arst_q",    bus_n.Q,    8'h00);
        chk("arst_vout", bus_n.vout, 1'b0);
        chk("arst_cnt",  bus_n.cnt,  3'd0);
        chk("arst_qall", bus_n.Qall, 32'h0);
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h77, 1'b1); tick_n();
        chk("arst_hold_qall", bus_n.Qall, 32'h0);
        r_n = 1'b0;
        #1;
        chk("arst_rel_qall", bus_n.Qall, 32'h0);
        chk("arst_rel_cnt",  bus_n.cnt,  3'd0);

        // Set beats enable/broadcast; reset beats set
        drive_n(1'b1, 1'b1, MODE_BCAST, 8'h5A, 1'b0); tick_n();
        chk("set_qall", bus_n.Qall, 32'hFFFFFFFF);
        chk("set_cnt",  bus_n.cnt,  3'd4);
        chk("set_vout", bus_n.vout, 1'b1);
        r_n = 1'b1;
        #1;
        m_reset();
        chk("rs_qall_async", bus_n.Qall, 32'h0);
        tick_n();
        chk("rs_qall", bus_n.Qall, 32'h0);
        chk("rs_cnt",  bus_n.cnt,  3'd0);
        r_n = 1'b0;

        // Preload 0x44332211 with valid bits 1011 (stage3..stage0)
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h44, 1'b1); tick_n();
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h33, 1'b0); tick_n();
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h22, 1'b1); tick_n();
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h11, 1'b1); tick_n();
        chk("pre_qall", bus_n.Qall, 32'h44332211);
        chk("pre_cnt",  bus_n.cnt,  3'd3);
        drive_n(1'b0, 1'b1, MODE_ROT, 8'hEE, 1'b0); tick_n();
        chk("rot_qall", bus_n.Qall, 32'h33221144);
        chk("rot_cnt",  bus_n.cnt,  3'd3);
        chk("rot_vout", bus_n.vout, 1'b0);
        drive_n(1'b0, 1'b0, MODE_BCAST, 8'hFF, 1'b1); tick_n();
        chk("e0_qall", bus_n.Qall, 32'h33221144);
        chk("e0_cnt",  bus_n.cnt,  3'd3);
        drive_n(1'b0, 1'b1, MODE_HOLD, 8'hFF, 1'b1); tick_n();
        chk("hold_qall", bus_n.Qall, 32'h33221144);
        chk("hold_cnt",  bus_n.cnt,  3'd3);

        // Broadcast with and without valid, then shift against full/empty
        drive_n(1'b0, 1'b1, MODE_BCAST, 8'hA5, 1'b0); tick_n();
        chk("bc0_qall", bus_n.Qall, 32'hA5A5A5A5);
        chk("bc0_cnt",  bus_n.cnt,  3'd0);
        chk("bc0_vout", bus_n.vout, 1'b0);
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h3C, 1'b1); tick_n();
        chk("bc0_sh_qall", bus_n.Qall, 32'hA5A5A53C);
        chk("bc0_sh_cnt",  bus_n.cnt,  3'd1);
        drive_n(1'b0, 1'b1, MODE_BCAST, 8'h0F, 1'b1); tick_n();
        chk("bc1_cnt", bus_n.cnt, 3'd4);
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h00, 1'b0); tick_n();
        chk("bc1_sh_cnt",  bus_n.cnt,  3'd3);
        chk("bc1_sh_qall", bus_n.Qall, 32'h0F0F0F00);
        drive_n(1'b0, 1'b1, MODE_SHIFT, 8'h00, 1'b1); tick_n();
        chk("full_sh_cnt", bus_n.cnt, 3'd3);
        drive_n(1'b0, 1'b0, MODE_SHIFT, 8'h00, 1'b0);

        // Rising-edge build: updates on posedge only
        @(posedge clk);
        #1;
        chk("pos_idle_qall", bus_p.Qall, 32'h0);
        bus_p.E = 1'b1; bus_p.vin = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            bus_p.D = din_p[k];
            @(negedge clk);
            #1;
            chk("pos_negedge_qall", bus_p.Qall, (k == 0) ? 32'h0 : exp_p[k-1]);
            @(posedge clk);
            #1;
            chk("pos_qall", bus_p.Qall, exp_p[k]);
        end
        bus_p.E = 1'b0;
        chk("pos_q",    bus_p.Q,    8'h11);
        chk("pos_vout", bus_p.vout, 1'b1);
        chk("pos_cnt",  bus_p.cnt,  3'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
